// File: rtl/bus_region_decoder_pkg.sv
// bus_region_decoder_pkg: shared FSM encodings and default ROM/RAM map constants
package bus_region_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ERROR  = 2'd2
    } state_t;

    localparam int DEF_ADDR_W = 13;
    localparam int DEF_NREG   = 2;
    localparam int DEF_WAIT_W = 4;

    localparam logic [2*13-1:0] DEF_REG_LO = {13'h1800, 13'h0000};
    localparam logic [2*13-1:0] DEF_REG_HI = {13'h1FFF, 13'h17FF};
    localparam logic [2*4-1:0]  DEF_REG_WS = {4'd0, 4'd2};

endpackage

// File: rtl/bus_region_decoder_region_match.sv
// bus_region_decoder_region_match: combinational region bound compare with lowest-index priority
module bus_region_decoder_region_match #(
    parameter int                         ADDR_W = 13,
    parameter int                         NREG   = 2,
    parameter int                         WAIT_W = 4,
    parameter logic [NREG*ADDR_W-1:0]     REG_LO = '0,
    parameter logic [NREG*ADDR_W-1:0]     REG_HI = '0,
    parameter logic [NREG*WAIT_W-1:0]     REG_WS = '0
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [NREG-1:0]   region_en,
    output logic              hit,
    output logic [NREG-1:0]   onehot,
    output logic [WAIT_W-1:0] ws
);

    logic [NREG-1:0] hits;

    // Bounds are checked through the borrow bit of a widened subtraction so a zero
    // low bound does not degenerate into an always-true unsigned compare.
    for (genvar g = 0; g < NREG; g++) begin : g_cmp
        logic [ADDR_W:0] d_lo;
        logic [ADDR_W:0] d_hi;
        assign d_lo    = {1'b0, addr} - {1'b0, REG_LO[g*ADDR_W +: ADDR_W]};
        assign d_hi    = {1'b0, REG_HI[g*ADDR_W +: ADDR_W]} - {1'b0, addr};
        assign hits[g] = region_en[g] & ~d_lo[ADDR_W] & ~d_hi[ADDR_W];
    end

    assign hit = |hits;

    // Priority encode: scan from the top so the lowest matching index overwrites last
    always_comb begin
        onehot = '0;
        ws     = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (hits[i]) begin
                onehot = NREG'(1) << i;
                ws     = REG_WS[i*WAIT_W +: WAIT_W];
            end
        end
    end

endmodule

// File: rtl/bus_region_decoder.sv
// bus_region_decoder: registered address decoder and wait-state bus sequencer
module bus_region_decoder
    import bus_region_decoder_pkg::*;
#(
    parameter int                     ADDR_W = DEF_ADDR_W,
    parameter int                     NREG   = DEF_NREG,
    parameter int                     WAIT_W = DEF_WAIT_W,
    parameter logic [NREG*ADDR_W-1:0] REG_LO = DEF_REG_LO,
    parameter logic [NREG*ADDR_W-1:0] REG_HI = DEF_REG_HI,
    parameter logic [NREG*WAIT_W-1:0] REG_WS = DEF_REG_WS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [NREG-1:0]   region_en,
    output logic [NREG-1:0]   sel,
    output logic [ADDR_W-1:0] sel_addr,
    output logic              sel_we,
    output logic              ack,
    output logic              err,
    output logic              busy
);

    state_t              state, state_nx;
    logic [WAIT_W-1:0]   cnt;
    logic                hit;
    logic [NREG-1:0]     onehot;
    logic [WAIT_W-1:0]   ws;
    logic                start;
    logic                waiting;

    bus_region_decoder_region_match #(
        .ADDR_W (ADDR_W),
        .NREG   (NREG),
        .WAIT_W (WAIT_W),
        .REG_LO (REG_LO),
        .REG_HI (REG_HI),
        .REG_WS (REG_WS)
    ) u_match (
        .addr      (addr),
        .region_en (region_en),
        .hit       (hit),
        .onehot    (onehot),
        .ws        (ws)
    );

    assign start   = (state == IDLE) && req;
    assign waiting = (state == ACCESS) && (cnt != '0);

    // State, wait counter and the captured transfer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            sel      <= '0;
            sel_addr <= '0;
            sel_we   <= 1'b0;
            err      <= 1'b0;
        end else begin
            state <= state_nx;
            err   <= start && !hit;
            sel   <= (start && hit) ? onehot : waiting ? sel : '0;
            cnt   <= start ? ws : waiting ? cnt - WAIT_W'(1) : cnt;
            if (start) begin
                sel_addr <= addr;
                sel_we   <= we;
            end
        end
    end

    // Next state plus the combinational ack and busy outputs
    always_comb begin
        state_nx = state;
        ack      = 1'b0;
        busy     = state != IDLE;
        case (state)
            IDLE:    state_nx = req ? (hit ? ACCESS : ERROR) : IDLE;
            ACCESS: begin
                ack      = cnt == '0;
                state_nx = (cnt == '0) ? IDLE : ACCESS;
            end
            ERROR:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bus_region_decoder.sv
// tb_bus_region_decoder: directed scoreboard bench for the region decoder
module tb_bus_region_decoder;

    typedef struct {
        string      tag;
        logic [1:0] sel;
        logic       ack;
        logic       err;
        logic       busy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [12:0] addr = '0;
    logic        we = 1'b0;
    logic [1:0]  region_en = 2'b11;
    logic [1:0]  sel;
    logic [12:0] sel_addr;
    logic        sel_we, ack, err, busy;
    logic [1:0]  sel2;
    logic [12:0] sel_addr2;
    logic        sel_we2, ack2, err2, busy2;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    bus_region_decoder dut (
        .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .we(we), .region_en(region_en),
        .sel(sel), .sel_addr(sel_addr), .sel_we(sel_we), .ack(ack), .err(err), .busy(busy)
    );

    bus_region_decoder #(
        .REG_LO({13'h0000, 13'h0000})
    ) dut_ovl (
        .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .we(we), .region_en(region_en),
        .sel(sel2), .sel_addr(sel_addr2), .sel_we(sel_we2), .ack(ack2), .err(err2), .busy(busy2)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cyc(input string tag, input logic [1:0] s, input logic a, input logic e, input logic b);
        exp_t x;
        x.tag = tag; x.sel = s; x.ack = a; x.err = e; x.busy = b;
        q.push_back(x);
    endtask

    task automatic chk();
        exp_t x;
        if (q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_empty got=%0d exp=>0", q.size());
            return;
        end
        x = q.pop_front();
        checks += 5;
        assert (sel === x.sel) else begin failures++; $error("FAIL %s.sel got=%b exp=%b", x.tag, sel, x.sel); end
        assert (ack === x.ack) else begin failures++; $error("FAIL %s.ack got=%b exp=%b", x.tag, ack, x.ack); end
        assert (err === x.err) else begin failures++; $error("FAIL %s.err got=%b exp=%b", x.tag, err, x.err); end
        assert (busy === x.busy) else begin failures++; $error("FAIL %s.busy got=%b exp=%b", x.tag, busy, x.busy); end
        assert (!(ack && err)) else begin failures++; $error("FAIL %s.ack_err got=%b exp=0", x.tag, ack && err); end
    endtask

    task automatic chk_val(input string tag, input logic [12:0] got, input logic [12:0] exp);
        checks++;
        assert (got === exp) else begin failures++; $error("FAIL %s got=%h exp=%h", tag, got, exp); end
    endtask

    initial begin
        // 1: reset held with req high, then released with req low
        req = 1'b1;
        repeat (3) begin
            step();
            expect_cyc("rst", 2'b00, 1'b0, 1'b0, 1'b0);
            chk();
        end
        chk_val("rst_sel_addr", sel_addr, 13'h0000);
        chk_val("rst_sel_we", {12'd0, sel_we}, 13'h0000);
        req = 1'b0;
        rst_n = 1'b1;
        repeat (2) begin
            step();
            expect_cyc("post_rst", 2'b00, 1'b0, 1'b0, 1'b0);
            chk();
        end

        // 2: ROM read with two wait states
        req = 1'b1; addr = 13'h0004; we = 1'b0;
        expect_cyc("rom_t1", 2'b01, 1'b0, 1'b0, 1'b1);
        expect_cyc("rom_t2", 2'b01, 1'b0, 1'b0, 1'b1);
        expect_cyc("rom_t3", 2'b01, 1'b1, 1'b0, 1'b1);
        expect_cyc("rom_t4", 2'b00, 1'b0, 1'b0, 1'b0);
        step(); req = 1'b0; addr = 13'h1555; chk();
        chk_val("rom_sel_addr", sel_addr, 13'h0004);
        chk_val("rom_sel_we", {12'd0, sel_we}, 13'h0000);
        chk_val("ovl_rom_sel", {11'd0, sel2}, 13'h0001);
        repeat (3) begin step(); chk(); end

        // 3: RAM write with zero waits, req held high for back-to-back
        req = 1'b1; addr = 13'h1800; we = 1'b1;
        expect_cyc("ram_t1", 2'b10, 1'b1, 1'b0, 1'b1);
        expect_cyc("ram_t2", 2'b00, 1'b0, 1'b0, 1'b0);
        expect_cyc("ram_t3", 2'b10, 1'b1, 1'b0, 1'b1);
        step(); chk();
        chk_val("ram_sel_we", {12'd0, sel_we}, 13'h0001);
        chk_val("ram_sel_addr", sel_addr, 13'h1800);
        step(); chk();
        step(); req = 1'b0; we = 1'b0; chk();
        expect_cyc("ram_idle", 2'b00, 1'b0, 1'b0, 1'b0);
        step(); chk();

        // 4: region boundaries and overlap priority
        req = 1'b1; addr = 13'h17FF;
        expect_cyc("rom_hi_t1", 2'b01, 1'b0, 1'b0, 1'b1);
        expect_cyc("rom_hi_t2", 2'b01, 1'b0, 1'b0, 1'b1);
        expect_cyc("rom_hi_t3", 2'b01, 1'b1, 1'b0, 1'b1);
        expect_cyc("rom_hi_t4", 2'b00, 1'b0, 1'b0, 1'b0);
        step(); req = 1'b0; chk();
        repeat (3) begin step(); chk(); end
        req = 1'b1; addr = 13'h1FFF;
        expect_cyc("ram_hi_t1", 2'b10, 1'b1, 1'b0, 1'b1);
        expect_cyc("ram_hi_t2", 2'b00, 1'b0, 1'b0, 1'b0);
        step(); req = 1'b0; chk();
        step(); chk();
        req = 1'b1; addr = 13'h1000;
        step(); req = 1'b0;
        chk_val("ovl_mid_sel", {11'd0, sel2}, 13'h0001);
        chk_val("main_mid_sel", {11'd0, sel}, 13'h0001);
        repeat (4) step();

        // 5: disabled region gives a single err pulse; req during ERROR ignored
        region_en = 2'b01; req = 1'b1; addr = 13'h1A00;
        expect_cyc("dis_t1", 2'b00, 1'b0, 1'b1, 1'b1);
        expect_cyc("dis_t2", 2'b00, 1'b0, 1'b0, 1'b0);
        expect_cyc("dis_t3", 2'b00, 1'b0, 1'b0, 1'b0);
        step(); chk();
        step(); req = 1'b0; chk();
        step(); chk();
        region_en = 2'b11;

        // 6: async reset in the middle of a ROM access
        req = 1'b1; addr = 13'h0000;
        expect_cyc("abort_t1", 2'b01, 1'b0, 1'b0, 1'b1);
        expect_cyc("abort_t2", 2'b01, 1'b0, 1'b0, 1'b1);
        step(); req = 1'b0; chk();
        step(); chk();
        #3 rst_n = 1'b0;
        #1;
        expect_cyc("abort_now", 2'b00, 1'b0, 1'b0, 1'b0);
        chk();
        step(); rst_n = 1'b1;
        repeat (3) begin
            expect_cyc("abort_after", 2'b00, 1'b0, 1'b0, 1'b0);
            chk();
            step();
        end
        req = 1'b1; addr = 13'h1800;
        expect_cyc("recover_t1", 2'b10, 1'b1, 1'b0, 1'b1);
        expect_cyc("recover_t2", 2'b00, 1'b0, 1'b0, 1'b0);
        step(); req = 1'b0; chk();
        chk_val("recover_sel_addr", sel_addr, 13'h1800);
        step(); chk();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
